// File: rtl/microsequencer.sv
// Next-address generator for the microprogrammed control unit: increment,
// dispatch, jump, branch, bounded memory-wait loops and a shallow call stack.
module microsequencer #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned FETCH_ADDR  = 1,
  parameter int unsigned STACK_DEPTH = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [2:0]        n_sel,
  input  logic [1:0]        cond_sel,
  input  logic              inv,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] decode_addr,
  input  logic              moc,
  input  logic              cond,
  input  logic              irq,
  output logic [ADDR_W-1:0] next_state,
  output logic [ADDR_W-1:0] state,
  output logic              stack_err,
  output logic              timeout_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] N_DISPATCH = 3'b000;
  localparam logic [2:0] N_FETCH    = 3'b001;
  localparam logic [2:0] N_INCR     = 3'b010;
  localparam logic [2:0] N_JUMP     = 3'b011;
  localparam logic [2:0] N_BRANCH   = 3'b100;
  localparam logic [2:0] N_WAIT     = 3'b101;
  localparam logic [2:0] N_CALL     = 3'b110;
  localparam logic [2:0] N_RETURN   = 3'b111;

  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [CNT_W-1:0]  sp;
  logic [TMR_W-1:0]  timer;

  logic              c_sel;
  logic              c;
  logic [ADDR_W-1:0] inc;
  logic [TMR_W-1:0]  timer_nxt;
  logic              do_push;
  logic              do_pop;
  logic              set_serr;
  logic              set_terr;

  // Next-address selection; stack[0] is always the top of stack.
  always_comb begin
    c_sel     = 1'b1;
    next_state = '0;
    timer_nxt = '0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    set_serr  = 1'b0;
    set_terr  = 1'b0;
    inc       = state + ADDR_W'(1);

    case (cond_sel)
      2'd0:    c_sel = moc;
      2'd1:    c_sel = cond;
      2'd2:    c_sel = irq;
      default: c_sel = 1'b1;
    endcase
    c = c_sel ^ inv;

    case (n_sel)
      N_DISPATCH: next_state = decode_addr;
      N_FETCH:    next_state = ADDR_W'(FETCH_ADDR);
      N_INCR:     next_state = inc;
      N_JUMP:     next_state = cr_addr;
      N_BRANCH:   next_state = c ? cr_addr : inc;
      N_WAIT: begin
        if (c) begin
          next_state = inc;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          next_state = ADDR_W'(FETCH_ADDR);
          set_terr   = 1'b1;
        end else begin
          next_state = state;
          timer_nxt  = timer + TMR_W'(1);
        end
      end
      N_CALL: begin
        next_state = cr_addr;
        do_push    = 1'b1;
        set_serr   = (sp == CNT_W'(STACK_DEPTH));
      end
      N_RETURN: begin
        if (sp == '0) begin
          next_state = ADDR_W'(FETCH_ADDR);
          set_serr   = 1'b1;
        end else begin
          next_state = stack[0];
          do_pop     = 1'b1;
        end
      end
      default: next_state = inc;
    endcase

    if (reset) next_state = '0;
  end

  // State, stack and timer commit; hold freezes everything but next_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= '0;
      sp          <= '0;
      timer       <= '0;
      stack_err   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack[i] <= '0;
    end else if (!hold) begin
      state       <= next_state;
      timer       <= timer_nxt;
      stack_err   <= stack_err | set_serr;
      timeout_err <= timeout_err | set_terr;
      if (do_push) begin
        // Shifting down drops the oldest entry when the stack is full.
        for (int i = int'(STACK_DEPTH) - 1; i > 0; i--) stack[i] <= stack[i-1];
        stack[0] <= inc;
        if (sp != CNT_W'(STACK_DEPTH)) sp <= sp + CNT_W'(1);
      end else if (do_pop) begin
        for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) stack[i] <= stack[i+1];
        stack[STACK_DEPTH-1] <= '0;
        sp <= sp - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: directed scenarios then random control
// words, checked against a queue-based reference model.
module tb_microsequencer;

  localparam int ADDR_W  = 10;
  localparam int FETCH   = 1;
  localparam int DEPTH   = 2;
  localparam int TMO     = 255;
  localparam int AMASK   = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hold = 1'b0;
  logic [2:0]        n_sel = 3'b010;
  logic [1:0]        cond_sel = 2'd0;
  logic              inv = 1'b0;
  logic [ADDR_W-1:0] cr_addr = '0;
  logic [ADDR_W-1:0] decode_addr = '0;
  logic              moc = 1'b0;
  logic              cond = 1'b0;
  logic              irq = 1'b0;
  logic [ADDR_W-1:0] next_state;
  logic [ADDR_W-1:0] state;
  logic              stack_err;
  logic              timeout_err;

  microsequencer #(.ADDR_W(ADDR_W), .FETCH_ADDR(FETCH), .STACK_DEPTH(DEPTH),
                   .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .hold(hold), .n_sel(n_sel), .cond_sel(cond_sel),
    .inv(inv), .cr_addr(cr_addr), .decode_addr(decode_addr), .moc(moc),
    .cond(cond), .irq(irq), .next_state(next_state), .state(state),
    .stack_err(stack_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nxt;
    int st;
    bit serr;
    bit terr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stim_done = 1'b0;

  // Reference model: address values as integers, stack as a queue (front = top).
  int m_state = 0;
  int m_wait  = 0;
  int m_stack[$];
  bit m_serr  = 1'b0;
  bit m_terr  = 1'b0;

  task automatic step(input bit rst, input bit h, input int ns, input int cs,
                      input bit iv, input int cr, input int dec,
                      input bit m, input bit cd, input bit iq);
    exp_t e;
    int   nxt, inc, wcount;
    bit   c, push, pop, se, te;
    @(posedge clk);
    #1;
    reset = rst; hold = h; n_sel = 3'(ns); cond_sel = 2'(cs); inv = iv;
    cr_addr = ADDR_W'(cr); decode_addr = ADDR_W'(dec);
    moc = m; cond = cd; irq = iq;

    c = ((cs == 0) ? m : (cs == 1) ? cd : (cs == 2) ? iq : 1'b1) ^ iv;
    inc = (m_state + 1) % (AMASK + 1);
    push = 0; pop = 0; se = 0; te = 0; wcount = 0; nxt = 0;
    case (ns)
      0: nxt = dec;
      1: nxt = FETCH;
      2: nxt = inc;
      3: nxt = cr;
      4: nxt = c ? cr : inc;
      5: begin
        if (c) nxt = inc;
        else if (m_wait + 1 >= TMO) begin nxt = FETCH; te = 1; end
        else begin nxt = m_state; wcount = m_wait + 1; end
      end
      6: begin nxt = cr; push = 1; se = (m_stack.size() == DEPTH); end
      default: begin
        if (m_stack.size() == 0) begin nxt = FETCH; se = 1; end
        else begin nxt = m_stack[0]; pop = 1; end
      end
    endcase
    if (rst) nxt = 0;

    e.nxt = nxt; e.st = m_state; e.serr = m_serr; e.terr = m_terr;
    exp_q.push_back(e);

    if (rst) begin
      m_state = 0; m_wait = 0; m_stack.delete(); m_serr = 0; m_terr = 0;
    end else if (!h) begin
      m_state = nxt;
      m_wait  = wcount;
      m_serr  = m_serr | se;
      m_terr  = m_terr | te;
      if (push) begin
        m_stack.push_front(inc);
        if (m_stack.size() > DEPTH) void'(m_stack.pop_back());
      end
      if (pop) void'(m_stack.pop_front());
    end
  endtask

  task automatic go(input int ns, input int cr);
    step(0, 0, ns, 3, 0, cr, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every negedge the DUT presents a fresh next_state/state pair.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("next_state", int'(next_state), e.nxt);
        check("state", int'(state), e.st);
        check("stack_err", int'(stack_err), int'(e.serr));
        check("timeout_err", int'(timeout_err), int'(e.terr));
      end
    end
  end

  initial begin
    // Reset for 3 cycles with incr selected, then count up.
    for (int i = 0; i < 3; i++) step(1, 0, 2, 3, 0, 0, 0, 0, 0, 0);
    go(2, 0); go(2, 0); go(2, 0);
    // Dispatch and fetch.
    go(3, 3);
    step(0, 0, 0, 3, 0, 0, 20, 0, 0, 0);
    go(1, 0);
    // Memory wait resolved after 4 cycles.
    go(3, 10);
    for (int i = 0; i < 4; i++) step(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 5, 0, 0, 0, 0, 1, 0, 0);
    // Wait timeout, then limit cycle with condition met.
    go(3, 10);
    for (int i = 0; i < TMO + 2; i++) step(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 2, 3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 5, 0, 0, 0, 0, 1, 0, 0);
    go(2, 0);
    // Nested call/return and return from empty.
    go(3, 5); go(6, 40); go(6, 50); go(7, 0); go(7, 0); go(7, 0); go(2, 0);
    // Branch with inverted condition, then hold.
    step(1, 0, 2, 3, 0, 0, 0, 0, 0, 0);
    go(3, 12);
    step(0, 0, 4, 1, 1, 30, 0, 0, 1, 0);
    step(0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
    step(0, 1, 6, 3, 0, 99, 0, 0, 0, 0);
    go(2, 0);
    // Address wrap and stack overflow dropping the oldest entry.
    go(3, AMASK); go(2, 0); go(2, 0);
    go(6, 100); go(6, 200); go(6, 300); go(7, 0); go(7, 0); go(7, 0);

    for (int i = 0; i < 4000; i++) begin
      int ns, cs;
      bit rst, h, m;
      rst = ($urandom_range(0, 99) == 0);
      h   = ($urandom_range(0, 7) == 0);
      ns  = $urandom_range(0, 7);
      cs  = $urandom_range(0, 3);
      m   = ($urandom_range(0, 3) == 0);
      step(rst, h, ns, cs, 1'($urandom), ($urandom_range(0, 9) == 0) ? AMASK :
           $urandom_range(0, AMASK), $urandom_range(0, AMASK),
           m, 1'($urandom), 1'($urandom));
    end

    stim_done = 1'b1;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
